// File: rtl/jk_step_driver.sv
// jk_step_driver: steps a bank of master-slave JK flip-flops one state at a
// time (mod-MODULUS up/down count, clear or invert). J/K are derived from the
// bank's real Q, and each resulting state is checked against its target.
module jk_step_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [7:0]       steps,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] M_UP     = 2'b00;
  localparam logic [1:0] M_DOWN   = 2'b01;
  localparam logic [1:0] M_CLEAR  = 2'b10;

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  logic [1:0]       step_mode;
  logic [WIDTH-1:0] tgt;

  // Target state one step away from c; out-of-range counts wrap to a legal value.
  function automatic logic [WIDTH-1:0] step_target(input logic [1:0]       m,
                                                   input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] t;
    t = '0;
    case (m)
      M_UP:    t = (c >= TOP) ? '0 : c + WIDTH'(1);
      M_DOWN:  t = ((c == '0) || (c > TOP)) ? TOP : c - WIDTH'(1);
      M_CLEAR: t = '0;
      default: t = ~c;
    endcase
    return t;
  endfunction

  // The first step uses the mode being accepted; later steps use the latched copy.
  always_comb begin
    step_mode = (state_q == S_IDLE) ? mode : mode_q;
    tgt       = step_target(step_mode, q_fb);
  end

  // Next-state logic: J/K are only nonzero for the single DRIVE cycle of a step.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    err_d   = err_q;
    j_d     = '0;
    k_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = steps;
          err_d  = 1'b0;
          if (steps == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
            exp_d   = tgt;
            j_d     = tgt & ~q_fb;
            k_d     = q_fb & ~tgt;
          end
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (q_fb != exp_q) begin
          err_d = 1'b1;
        end
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
        end else begin
          // Next step starts from the bank's real state, not from exp_q.
          state_d = S_DRIVE;
          exp_d   = tgt;
          j_d     = tgt & ~q_fb;
          k_d     = q_fb & ~tgt;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  assign j        = j_q;
  assign k        = k_q;
  assign expected = exp_q;
  assign err      = err_q;
  assign busy     = (state_q == S_DRIVE) || (state_q == S_SETTLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_jk_step_driver.sv
// Bench for jk_step_driver: a behavioural master-slave JK bank closes the
// loop, with an optional stuck-at-0 mask on its Q feedback for fault runs.
module tb_jk_step_driver;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [7:0]   steps = 8'd0;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k, expected;
  logic         busy, done, err;

  logic [W-1:0] bank_m = '0;
  logic [W-1:0] bank_s = '0;
  logic         load_en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] stuck = '0;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] e;
    logic         err;
  } rec_t;
  rec_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  jk_step_driver #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .steps(steps),
    .q_fb(q_fb), .j(j), .k(k), .expected(expected),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // JK bank: master captures on rising edge, slave follows on falling edge.
  always @(posedge clk) bank_m <= j | (bank_s & ~k);
  always @(negedge clk) bank_s <= load_en ? load_val : bank_m;
  assign q_fb = bank_s & ~stuck;

  function automatic logic [W-1:0] ref_next(input logic [1:0] m, input logic [W-1:0] c);
    int unsigned ci;
    ci = c;
    case (m)
      2'b00:   return (ci >= MOD - 1) ? W'(0) : W'(ci + 1);
      2'b01:   return (ci == 0 || ci > MOD - 1) ? W'(MOD - 1) : W'(ci - 1);
      2'b10:   return W'(0);
      default: return ~c;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [W-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    #1;
    load_en = 1'b0;
    tick();
  endtask

  // One full run: scoreboard filled from the bank model, then popped per step.
  task automatic run(input string tag, input logic [1:0] m, input logic [7:0] n,
                     input logic [W-1:0] init, input logic [W-1:0] stk, input bit poke);
    logic [W-1:0] qi, c, nx, last_e;
    logic         e;
    rec_t         r;
    stuck = stk;
    preload(init);
    qi = init; c = init & ~stk; e = 1'b0; last_e = '0;
    for (int i = 0; i < int'(n); i++) begin
      nx = ref_next(m, c);
      sb.push_back('{j: nx & ~c, k: c & ~nx, e: nx, err: e});
      qi = (nx & ~c) | (qi & ~(c & ~nx));
      c  = qi & ~stk;
      if (c != nx) e = 1'b1;
      last_e = nx;
    end
    mode = m; steps = n; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      r = sb.pop_front();
      chk({tag, "_j"}, 32'(j), 32'(r.j));
      chk({tag, "_k"}, 32'(k), 32'(r.k));
      chk({tag, "_exp"}, 32'(expected), 32'(r.e));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(done), 32'd0);
      chk({tag, "_err_mid"}, 32'(err), 32'(r.err));
      if (poke && i == 0) begin
        start = 1'b1; steps = 8'd7; mode = ~m;
      end
      tick();
      start = 1'b0;
      chk({tag, "_settle_jk"}, 32'({j, k}), 32'd0);
      chk({tag, "_settle_busy"}, 32'(busy), 32'd1);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_jk"}, 32'({j, k}), 32'd0);
    chk({tag, "_err_end"}, 32'(err), 32'(e));
    if (n != 8'd0) chk({tag, "_exp_end"}, 32'(expected), 32'(last_e));
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    stuck = '0;
  endtask

  initial begin
    #2;
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_exp", 32'(expected), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    run("up8",    2'b00, 8'd3, 4'd8,     4'b0000, 1'b1);
    run("down0",  2'b01, 8'd2, 4'd0,     4'b0000, 1'b0);
    run("up12",   2'b00, 8'd1, 4'd12,    4'b0000, 1'b0);
    run("fault",  2'b00, 8'd2, 4'd0,     4'b0001, 1'b0);
    run("zero",   2'b00, 8'd0, 4'd5,     4'b0000, 1'b1);
    run("inv",    2'b11, 8'd1, 4'b0101,  4'b0000, 1'b0);
    run("clr",    2'b10, 8'd1, 4'b1111,  4'b0000, 1'b0);
    run("upwrap", 2'b00, 8'd12, 4'd0,    4'b0000, 1'b0);

    // Abandon a run with reset while in DRIVE.
    preload(4'd3);
    mode = 2'b00; steps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_j", 32'(j), 32'b0100);
    chk("mid_k", 32'(k), 32'b0011);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_jk", 32'({j, k}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_exp", 32'(expected), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("bank_held", 32'(q_fb), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jk_step_driver.md
# jk_step_driver

Sequencing stage directly upstream of a bank of WIDTH master-slave JK flip-flops. It reads the bank's Q outputs back, computes per-bit J/K excitation that moves the bank one step toward a target state (mod-MODULUS up/down count, clear, or invert), and runs a requested number of steps. After each step it checks the bank's actual next state against the expected value and reports any mismatch. It gives the control path a start/done handshake so that a JK register bank can be used as a checked counter.

## Interface
- WIDTH, 4: number of JK flip-flops driven; 1..8.
- MODULUS, 10: count wrap value for up/down modes; 2..2^WIDTH.

- clk  input  1  single clock; the flop bank uses the same clk (master on rising edge, slave on falling edge).
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  request pulse; accepted only in IDLE.
- mode  input  2  00 up-count, 01 down-count, 10 clear, 11 invert-all; latched on accept.
- steps  input  8  number of steps to run; latched on accept.
- q_fb  input  WIDTH  Q outputs of the driven flop bank.
- j  output  WIDTH  J inputs to the flop bank, registered.
- k  output  WIDTH  K inputs to the flop bank, registered.
- expected  output  WIDTH  target state of the step in progress, or of the last step.
- busy  output  1  high in DRIVE and SETTLE.
- done  output  1  one-cycle pulse when the run completes.
- err  output  1  sticky mismatch flag; cleared when the next start is accepted.

## Operation
- States: IDLE, DRIVE, SETTLE, DONE.
- IDLE: j = k = 0.
  - When start=1, the block latches mode and steps, loads the remaining-step count with steps, and clears err.
  - If steps==0 it goes to DONE. Otherwise it goes to DRIVE.
- Entry into DRIVE, at the same clock edge:
  - Sample q_fb as c.
  - Compute n = next(c) and register expected <= n.
  - Register j/k per bit:
    - c==n gives J=0, K=0.
    - 0->1 gives J=1, K=0.
    - 1->0 gives J=0, K=1.
  - J=K=1 is never driven.
- DRIVE (1 cycle) -> SETTLE. On this edge j and k return to 0.
- SETTLE (1 cycle), at the ending edge:
  - If q_fb != expected, set err=1.
  - Decrement the remaining-step count.
  - If the count was 1, go to DONE. Otherwise re-enter DRIVE, sampling q_fb at this same edge.
- DONE (1 cycle): done=1, busy=0, start is ignored; then go to IDLE.
- next() by mode, all arithmetic WIDTH bits unsigned:
  - Up: if c >= MODULUS-1 then 0, else c+1.
  - Down: if c==0 or c > MODULUS-1 then MODULUS-1, else c-1.
  - Clear: 0.
  - Invert: ~c, with no modulus limit.
- err does not abort the run. All remaining steps are still executed.
- Each step computes its target from the actual q_fb, not from the previous expected value, so a faulty bank is stepped from its real state.
- start, mode and steps are ignored while busy or in DONE.

## Timing
- Reset (reset_n=0, immediate, independent of clk):
  - state = IDLE.
  - j = k = 0, expected = 0, busy = 0, done = 0, err = 0.
  - Remaining-step count = 0.
- Reset during a run abandons the run with no done pulse. The bank sees J=K=0 and holds its state.
- Let the accept edge be E0.
  - Step i (1-based): j/k are valid in the cycle after edge E(2i-2); the check happens at edge E(2i).
  - done is high in the cycle after edge E(2N). With steps==0, done is high in the cycle after E0.
- Each step is 2 cycles: the bank master captures j/k at the DRIVE-ending edge and the slave updates on the following falling edge. q_fb is therefore stable before the SETTLE-ending edge.
- busy is high from the cycle after E0 through the last SETTLE cycle; it is low in DONE.
- In the cycle after done, start may be accepted again.

## Test plan
- Reset with q_fb=0: all outputs 0. Assert reset_n=0 mid-run in DRIVE -> j=k=0, busy=0 immediately; no done pulse.
- Up count, MODULUS=10, bank at 8, steps=3:
  - expected = 9, then 0, then 1.
  - First step's j/k: j=0001, k=0000.
  - Second step (9->0): j=0000, k=1001.
  - done in the cycle after E6; err=0.
- Down count from 0 with steps=2 -> expected = 9, then 8. Out-of-range q_fb=12 in up mode -> expected=0.
- Fault injection: hold q_fb bit0 stuck at 0, up count from 0, steps=2 -> err=1 after the first check. The second step is driven from the real q_fb=0 (expected=1 again); err stays 1 through done and clears on the next accepted start.
- steps=0 -> done in the cycle after E0; j/k never nonzero. A start pulse while busy or in DONE is ignored; steps of the active run are unchanged.
- Invert mode with q_fb=0101, steps=1 -> j=1010, k=0101, expected=1010; clear mode from 1111 -> k=1111, expected=0000.
